wave_gen: RTL and testbench



---
 rtl/wave_gen_pkg.sv | 40 ++++
 rtl/wave_shaper.sv | 38 +++
 rtl/wave_gen.sv | 132 +++++++++++++
 tb/tb_wave_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_gen_pkg.sv
// rtl/wave_gen_pkg.sv - shared types, reset defaults and tuning-word helper for wave_gen
//
// Contents:
//   mode_e        waveform select (saw, triangle, square, mute)
//   cfg_t         one oscillator configuration {fcw, mode, duty}
//   DUTY_DEFAULT  square threshold after reset
//   MODE_DEFAULT  waveform after reset
//   fcw_from_freq tuning word for a note frequency at a given sample rate
package wave_gen_pkg;

    // Widest supported phase accumulator; cfg_t carries fcw at this width
    // and wave_gen uses the low phase_width_p bits.
    localparam int unsigned FCW_W = 32;

    typedef enum logic [1:0] {
        MODE_SAW  = 2'd0,
        MODE_TRI  = 2'd1,
        MODE_SQR  = 2'd2,
        MODE_MUTE = 2'd3
    } mode_e;

    typedef struct packed {
        logic [FCW_W-1:0] fcw;
        mode_e            mode;
        logic [7:0]       duty;
    } cfg_t;

    localparam logic [7:0] DUTY_DEFAULT = 8'd128;
    localparam mode_e      MODE_DEFAULT = MODE_TRI;

    // Rounded fcw = note_hz * 2^phase_w / fs_hz.
    function automatic logic [FCW_W-1:0] fcw_from_freq(input int unsigned note_hz,
                                                       input int unsigned fs_hz,
                                                       input int unsigned phase_w);
        longint unsigned num;
        num = (longint'(note_hz) << phase_w) + longint'(fs_hz / 2);
        return FCW_W'(num / longint'(fs_hz));
    endfunction

endpackage

// File: rtl/wave_shaper.sv
// rtl/wave_shaper.sv - combinational map of phase top bits to a signed sample
//
// Ports:
//   t       in   width_p  top width_p bits of the phase accumulator (unsigned)
//   mode    in   2        mode_e waveform select
//   duty    in   8        square high-time threshold (of 256)
//   sample  out  width_p  two's complement sample
module wave_shaper
    import wave_gen_pkg::*;
#(
    parameter int width_p = 12
) (
    input  logic [width_p-1:0] t,
    input  logic [1:0]         mode,
    input  logic [7:0]         duty,
    output logic [width_p-1:0] sample
);

    localparam logic [width_p-1:0] HALF     = {1'b1, {(width_p-1){1'b0}}};
    localparam logic [width_p-1:0] FULL_POS = {1'b0, {(width_p-1){1'b1}}};
    // -(HALF-1) modulo 2^width_p
    localparam logic [width_p-1:0] FULL_NEG = {1'b1, {(width_p-2){1'b0}}, 1'b1};

    logic [width_p-2:0] fold;

    always_comb begin
        // Second half of the cycle mirrors the first, giving the falling edge.
        fold   = t[width_p-1] ? ~t[width_p-2:0] : t[width_p-2:0];
        sample = '0;
        case (mode_e'(mode))
            MODE_SAW: sample = t - HALF;
            MODE_TRI: sample = {fold, 1'b0} - HALF;
            MODE_SQR: sample = (t[width_p-1 -: 8] < duty) ? FULL_POS : FULL_NEG;
            default:  sample = '0;    // mute
        endcase
    end

endmodule

// File: rtl/wave_gen.sv
// rtl/wave_gen.sv - phase-accumulator oscillator with handshaked, wrap-aligned config
//
// Optional feature macro: WAVE_GEN_HARD_SYNC_EN (adds sync_i hard phase reset).
//
// Ports:
//   clk_i        in   1              clock
//   reset_ni     in   1              asynchronous active-low reset
//   sync_i       in   1              (WAVE_GEN_HARD_SYNC_EN only) force phase to 0
//   cfg_valid_i  in   1              configuration offered
//   cfg_ready_o  out  1              configuration can be accepted
//   fcw_i        in   phase_width_p  frequency tuning word
//   mode_i       in   2              0=saw 1=triangle 2=square 3=mute
//   duty_i       in   8              square high-time threshold (of 256)
//   ready_i      in   1              downstream accepts sample
//   valid_o      out  1              sample valid
//   data_o       out  width_p        signed sample
module wave_gen
    import wave_gen_pkg::*;
#(
    parameter int width_p       = 12,
    parameter int phase_width_p = 24,
    parameter int default_fcw_p = 167398
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
`ifdef WAVE_GEN_HARD_SYNC_EN
    input  logic                     sync_i,
`endif
    input  logic                     cfg_valid_i,
    output logic                     cfg_ready_o,
    input  logic [phase_width_p-1:0] fcw_i,
    input  logic [1:0]               mode_i,
    input  logic [7:0]               duty_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [width_p-1:0]       data_o
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_PEND = 1'b1;

    localparam cfg_t CFG_RESET = '{fcw: FCW_W'(default_fcw_p), mode: MODE_DEFAULT, duty: DUTY_DEFAULT};

    logic                     state;
    logic [phase_width_p-1:0] phase;
    cfg_t                     active_cfg;
    cfg_t                     pend_cfg;

    logic                     sync;
    logic                     accept;
    logic                     cfg_hs;
    logic                     wrap;
    logic                     apply_pend;
    logic [FCW_W:0]           phase_sum;
    logic [phase_width_p-1:0] phase_next;
    logic [width_p-1:0]       shape_t;
    mode_e                    shape_mode;
    logic [7:0]               shape_duty;
    logic [width_p-1:0]       shape_out;
    logic                     unused_sum;

`ifdef WAVE_GEN_HARD_SYNC_EN
    assign sync = sync_i;
`else
    assign sync = 1'b0;
`endif

    // valid_o doubles as "out of reset": nothing is offered or accepted
    // until the first sample has been loaded.
    assign cfg_ready_o = valid_o & (state == ST_IDLE);
    assign accept      = valid_o & ready_i;
    assign cfg_hs      = cfg_valid_i & cfg_ready_o;

    // Carry out of bit phase_width_p-1 marks the phase wrap.
    assign phase_sum  = {1'b0, FCW_W'(phase)} + {1'b0, active_cfg.fcw};
    assign phase_next = phase_sum[phase_width_p-1:0];
    assign wrap       = phase_sum[phase_width_p];
    assign unused_sum = ^phase_sum;

    // A zero tuning word never wraps, so it must not block a pending config.
    assign apply_pend = (state == ST_PEND) &
                        (sync | (accept & (wrap | (active_cfg.fcw == '0))));

    // The sample loaded on the apply edge already uses the new shape,
    // while the increment above still uses the old fcw.
    assign shape_mode = apply_pend ? pend_cfg.mode : active_cfg.mode;
    assign shape_duty = apply_pend ? pend_cfg.duty : active_cfg.duty;
    assign shape_t    = (sync | ~valid_o) ? '0 : phase_next[phase_width_p-1 -: width_p];

    wave_shaper #(
        .width_p (width_p)
    ) u_shaper (
        .t      (shape_t),
        .mode   (shape_mode),
        .duty   (shape_duty),
        .sample (shape_out)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state      <= ST_IDLE;
            phase      <= '0;
            data_o     <= '0;
            valid_o    <= 1'b0;
            active_cfg <= CFG_RESET;
            pend_cfg   <= CFG_RESET;
        end else begin
            valid_o <= 1'b1;

            if (sync) begin
                phase <= '0;
            end else if (accept) begin
                phase <= phase_next;
            end

            if (sync || !valid_o || accept) begin
                data_o <= shape_out;
            end

            // apply_pend needs PEND and cfg_hs needs IDLE, so at most one fires.
            if (apply_pend) begin
                active_cfg <= pend_cfg;
                state      <= ST_IDLE;
            end
            if (cfg_hs) begin
                pend_cfg <= '{fcw: FCW_W'(fcw_i), mode: mode_e'(mode_i), duty: duty_i};
                state    <= ST_PEND;
            end
        end
    end

endmodule

// File: tb/tb_wave_gen.sv
// tb/tb_wave_gen.sv - scoreboard bench for wave_gen
`timescale 1ns/1ps
module tb_wave_gen;

    localparam int W  = 12;
    localparam int PW = 24;
    localparam int unsigned PMOD = 32'h0100_0000;

    logic          clk;
    logic          reset_ni;
    logic          cfg_valid_i;
    logic          cfg_ready_o;
    logic [PW-1:0] fcw_i;
    logic [1:0]    mode_i;
    logic [7:0]    duty_i;
    logic          ready_i;
    logic          valid_o;
    logic [W-1:0]  data_o;
`ifdef WAVE_GEN_HARD_SYNC_EN
    logic          sync_i;
`endif

    wave_gen #(
        .width_p       (W),
        .phase_width_p (PW),
        .default_fcw_p (167398)
    ) dut (
        .clk_i       (clk),
        .reset_ni    (reset_ni),
`ifdef WAVE_GEN_HARD_SYNC_EN
        .sync_i      (sync_i),
`endif
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .fcw_i       (fcw_i),
        .mode_i      (mode_i),
        .duty_i      (duty_i),
        .ready_i     (ready_i),
        .valid_o     (valid_o),
        .data_o      (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    bit done;
    int exp_q[$];

    int unsigned m_ph, m_fcw, m_mode, m_duty;
    int unsigned p_fcw, p_mode, p_duty;
    bit          m_pend;

    function automatic void check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int sdata();
        return int'($signed(data_o));
    endfunction

    // Reference waveform written straight from the arithmetic definitions.
    function automatic int wave_ref(input int unsigned ph, input int unsigned mode,
                                    input int unsigned duty);
        int t;
        t = int'(ph >> 12);
        case (mode)
            0: return t - 2048;
            1: return (t < 2048) ? (2 * t - 2048) : (6142 - 2 * t);
            2: return ((t >> 4) < int'(duty)) ? 2047 : -2047;
            default: return 0;
        endcase
    endfunction

    function automatic void apply_pending();
        m_fcw  = p_fcw;
        m_mode = p_mode;
        m_duty = p_duty;
        m_pend = 1'b0;
    endfunction

    // Drive one cycle of inputs at the falling edge and predict what the
    // next rising edge does to the model.
    task automatic cycle(input bit rdy, input bit cv = 1'b0, input int unsigned fcw = 0,
                         input int unsigned mode = 0, input int unsigned duty = 0,
                         input bit sy = 1'b0);
        bit hs;
        int unsigned nph;
        @(negedge clk);
        ready_i     = rdy;
        cfg_valid_i = cv;
        fcw_i       = PW'(fcw);
        mode_i      = 2'(mode);
        duty_i      = 8'(duty);
`ifdef WAVE_GEN_HARD_SYNC_EN
        sync_i      = sy;
`endif
        hs = cv && cfg_ready_o;
        if (sy) begin
            m_ph = 0;
            if (m_pend) apply_pending();
            exp_q.delete();
            exp_q.push_back(wave_ref(0, m_mode, m_duty));
        end else if (valid_o && rdy) begin
            nph = m_ph + m_fcw;
            if (m_pend && (nph >= PMOD || m_fcw == 0)) apply_pending();
            m_ph = nph % PMOD;
            exp_q.push_back(wave_ref(m_ph, m_mode, m_duty));
        end
        if (hs) begin
            p_fcw  = fcw % PMOD;
            p_mode = mode;
            p_duty = duty;
            m_pend = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset_ni    = 1'b0;
        ready_i     = 1'b0;
        cfg_valid_i = 1'b0;
`ifdef WAVE_GEN_HARD_SYNC_EN
        sync_i      = 1'b0;
`endif
        exp_q.delete();
        m_ph = 0; m_fcw = 167398; m_mode = 1; m_duty = 128; m_pend = 1'b0;
        repeat (2) @(negedge clk);
        reset_ni = 1'b1;
        exp_q.push_back(wave_ref(0, 1, 128));
    endtask

    // Run with ready high until the pending config has been taken, then one
    // more cycle so the first new-shape sample is on data_o.
    task automatic wait_apply(input string name);
        int n;
        n = 0;
        while (m_pend && n < 300) begin
            cycle(1'b1);
            n++;
        end
        if (m_pend) check({name, "_apply_timeout"}, 0, 1);
        cycle(1'b1);
    endtask

    // Monitor: every transferred sample is popped and compared.
    initial begin
        while (!done) begin
            @(negedge clk);
            #1;
            if (!done && reset_ni && valid_o && ready_i) begin
                if (exp_q.size() == 0) check("sample_unexpected", sdata(), 99999);
                else check("sample", sdata(), exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish (n_vec %0d)", n_vec);
        $fatal(1);
    end

    initial begin
        n_vec = 0; n_err = 0; done = 1'b0;
        reset_ni = 1'b0; ready_i = 1'b0; cfg_valid_i = 1'b0;
        fcw_i = '0; mode_i = '0; duty_i = '0;
`ifdef WAVE_GEN_HARD_SYNC_EN
        sync_i = 1'b0;
`endif
        @(negedge clk);
        check("rst_valid", int'(valid_o), 0);
        check("rst_data", sdata(), 0);
        check("rst_cfg_ready", int'(cfg_ready_o), 0);

        // Defaults: triangle at the reset tuning word
        do_reset();
        cycle(1'b1);
        check("first_sample", sdata(), -2048);
        check("first_cfg_ready", int'(cfg_ready_o), 1);
        cycle(1'b1);
        check("second_sample", sdata(), -1968);
        repeat (200) cycle(1'b1);

        // Saw, fcw 2^20; wrap after 101 default steps lands at phase 129982 (t=31)
        do_reset();
        cycle(1'b1);
        cycle(1'b1, 1'b1, 32'h0010_0000, 0, 128);
        cycle(1'b1);
        check("cfg_ready_pend", int'(cfg_ready_o), 0);
        wait_apply("saw");
        check("saw_first", sdata(), -2017);
        check("cfg_ready_back", int'(cfg_ready_o), 1);
        cycle(1'b1);
        check("saw_step", sdata(), -1761);
        repeat (15) cycle(1'b1);
        check("saw_period", sdata(), -2017);

        // Triangle, fcw 2^20
        cycle(1'b1, 1'b1, 32'h0010_0000, 1, 128);
        wait_apply("tri");
        check("tri_first", sdata(), -1986);
        repeat (8) cycle(1'b1);
        check("tri_fall", sdata(), 1984);

        // Square duty 128, then duty 0
        cycle(1'b1, 1'b1, 32'h0010_0000, 2, 128);
        wait_apply("sqr");
        check("sqr_high_first", sdata(), 2047);
        repeat (7) cycle(1'b1);
        check("sqr_high_last", sdata(), 2047);
        cycle(1'b1);
        check("sqr_low_first", sdata(), -2047);
        cycle(1'b1, 1'b1, 32'h0010_0000, 2, 0);
        wait_apply("sqr0");
        check("duty0_a", sdata(), -2047);
        repeat (5) cycle(1'b1);
        check("duty0_b", sdata(), -2047);

        // Random backpressure, including while a config is pending
        cycle(1'b1, 1'b1, 300001, 0, 0);
        repeat (150) cycle(1'($urandom_range(0, 1)));
        wait_apply("rand");

        // Reset while a config is pending
        cycle(1'b1, 1'b1, 32'h0010_0000, 2, 128);
        wait_apply("sqr_pre_rst");
        cycle(1'b1, 1'b1, 12345, 0, 50);
        cycle(1'b0);
        #3;
        reset_ni = 1'b0;
        #1;
        check("async_rst_valid", int'(valid_o), 0);
        check("async_rst_data", sdata(), 0);
        check("async_rst_cfg_ready", int'(cfg_ready_o), 0);
        do_reset();
        cycle(1'b1);
        check("post_rst_sample", sdata(), -2048);
        check("post_rst_cfg_ready", int'(cfg_ready_o), 1);
        repeat (120) cycle(1'b1);

`ifdef WAVE_GEN_HARD_SYNC_EN
        // Sync while stalled applies the pending square config at phase 0
        cycle(1'b0, 1'b1, 32'h0010_0000, 2, 128);
        cycle(1'b0, 1'b0, 0, 0, 0, 1'b1);
        cycle(1'b0);
        check("sync_sample", sdata(), 2047);
        check("sync_cfg_ready", int'(cfg_ready_o), 1);
        repeat (20) cycle(1'b1);
`endif

        cycle(1'b0);
        check("queue_depth", exp_q.size(), 1);
        done = 1'b1;
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
